// File: rtl/btn_pkg.sv
// btn_pkg: shared types and board timing constants for the
// pushbutton conditioning stage (state enum, 100 MHz defaults).
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD_WAIT = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  // Cycle counts at the 100 MHz board clock.
  localparam int unsigned DEBOUNCE_10MS = 1000000;
  localparam int unsigned REPEAT_500MS  = 50000000;
  localparam int unsigned REPEAT_100MS  = 10000000;

endpackage

// File: rtl/btn_toggle_pulser_sync_debounce.sv
// sync_debounce: pin synchroniser, polarity fix, debounce counter.
// Ports: clk, reset, btn_in (raw pin), level (1=pressed),
// change (high in the cycle before level flips at the next edge).
module sync_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic change
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // change is combinational so the top can register its
  // pulses on the same edge that level flips.
  always_comb begin
    cnt_d  = '0;
    change = 1'b0;
    if (s != level) begin
      if (cnt_q == CNT_LAST) begin
        change = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset value of the raw flops is the idle pin level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      cnt_q  <= cnt_d;
      if (change) begin
        level <= s;
      end
    end
  end

endmodule

// File: rtl/btn_toggle_pulser.sv
// btn_toggle_pulser: press/release pulses with optional auto-repeat.
// Ports: clk, reset, btn_in, btn_level, press_pulse, release_pulse, repeat_active.
module btn_toggle_pulser
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_active
);

  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  btn_state_e    state_q;
  btn_state_e    state_d;
  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;
  logic          change;
  logic          press_ev;
  logic          release_ev;
  logic          press_d;
  logic          release_d;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn_in),
    .level (btn_level),
    .change(change)
  );

  assign press_ev   = change & ~btn_level;
  assign release_ev = change & btn_level;

  // Release is tested first so it wins over a repeat expiry.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (press_ev) begin
          state_d = HELD_WAIT;
          rcnt_d  = '0;
          press_d = 1'b1;
        end
      end
      HELD_WAIT: begin
        if (release_ev) begin
          state_d   = RELEASED;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else if (REPEAT_EN) begin
          if (rcnt_q == DLY_LAST) begin
            state_d = REPEATING;
            rcnt_d  = '0;
            press_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      REPEATING: begin
        if (release_ev) begin
          state_d   = RELEASED;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else if (rcnt_q == PER_LAST) begin
          rcnt_d  = '0;
          press_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RELEASED;
      rcnt_q        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  assign repeat_active = (state_q == REPEATING);

endmodule

// File: tb/tb_btn_toggle_pulser.sv
// tb_btn_toggle_pulser: three instances (plain, auto-repeat,
// active-low feeding a toggle flop) checked against a window model.
module tb_btn_toggle_pulser;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic [2:0] lvl;
  logic [2:0] pp;
  logic [2:0] rp;
  logic [2:0] ra;
  logic       tq;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  bit hist [3][16];
  bit m_lvl [3];
  bit m_pp [3];
  bit m_rp [3];
  bit m_ra [3];
  bit held [3];
  int pstart [3];

  always #5 clk = ~clk;

  btn_toggle_pulser #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u0 (
    .clk(clk), .reset(reset), .btn_in(btn[0]),
    .btn_level(lvl[0]), .press_pulse(pp[0]),
    .release_pulse(rp[0]), .repeat_active(ra[0])
  );

  btn_toggle_pulser #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u1 (
    .clk(clk), .reset(reset), .btn_in(btn[1]),
    .btn_level(lvl[1]), .press_pulse(pp[1]),
    .release_pulse(rp[1]), .repeat_active(ra[1])
  );

  btn_toggle_pulser #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u2 (
    .clk(clk), .reset(reset), .btn_in(btn[2]),
    .btn_level(lvl[2]), .press_pulse(pp[2]),
    .release_pulse(rp[2]), .repeat_active(ra[2])
  );

  always @(posedge clk) begin
    if (reset) tq <= 1'b0;
    else if (pp[2]) tq <= ~tq;
  end

  function automatic bit rep_of(input int i);
    return i == 1;
  endfunction

  function automatic bit al_of(input int i);
    return i == 2;
  endfunction

  // Model: level flips when the last DC synchronised samples all
  // disagree with it; repeats fall at P+RD+n*RP while held.
  initial forever begin
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      bit acc;
      int d;
      m_pp[i] = 1'b0;
      m_rp[i] = 1'b0;
      if (reset) begin
        for (int j = 0; j < 16; j++) hist[i][j] = 1'b0;
        m_lvl[i] = 1'b0;
        held[i]  = 1'b0;
      end else begin
        for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = btn[i] ^ al_of(i);
        acc = 1'b1;
        for (int j = SS; j < SS + DC; j++)
          if (hist[i][j] == m_lvl[i]) acc = 1'b0;
        if (acc && !m_lvl[i]) begin
          m_lvl[i]  = 1'b1;
          m_pp[i]   = 1'b1;
          held[i]   = 1'b1;
          pstart[i] = edge_n;
        end else if (acc && m_lvl[i]) begin
          m_lvl[i] = 1'b0;
          m_rp[i]  = 1'b1;
          held[i]  = 1'b0;
        end else if (held[i] && rep_of(i)) begin
          d = edge_n - pstart[i];
          if (d >= RD && (d - RD) % RP == 0) m_pp[i] = 1'b1;
        end
      end
      m_ra[i] = held[i] && rep_of(i) && (edge_n - pstart[i] >= RD);
    end
  end

  initial forever begin
    @(negedge clk);
    if (edge_n > 0) begin
      for (int i = 0; i < 3; i++) begin
        logic [3:0] got;
        logic [3:0] exp;
        got = {lvl[i], pp[i], rp[i], ra[i]};
        exp = {m_lvl[i], m_pp[i], m_rp[i], m_ra[i]};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL model u%0d edge %0d: got %b want %b",
                   i, edge_n, got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] got,
                     input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    btn   = 3'b101;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("rst_outs", {lvl, pp, rp, ra}, 12'h000);
    end
    reset = 1'b0;
    step(5);
    chk("rst_edge5", {lvl[0], pp[0]}, 2'b00);
    step(1);
    chk("rst_edge6", {lvl[0], pp[0], m_pp[0]}, 3'b111);
    step(1);
    chk("rst_edge7", {lvl[0], pp[0]}, 2'b10);

    btn[0] = 1'b0;
    step(5);
    chk("rel_edge5", {lvl[0], rp[0]}, 2'b10);
    step(1);
    chk("rel_edge6", {lvl[0], rp[0], m_rp[0]}, 3'b011);
    step(1);
    chk("rel_edge7", rp[0], 1'b0);
    step(3);

    btn[0] = 1'b1;
    step(6);
    chk("press_edge6", {lvl[0], pp[0]}, 2'b11);
    step(10);
    chk("press_hold", {lvl[0], pp[0], ra[0]}, 3'b100);
    btn[0] = 1'b0;
    step(6);
    chk("release_edge6", {lvl[0], rp[0]}, 2'b01);
    step(2);

    btn[0] = 1'b1; step(3);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(2);
    btn[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("bounce_quiet", {lvl[0], pp[0], rp[0], ra[0]}, 4'h0);
    end

    btn[1] = 1'b1;
    step(6);
    chk("rep_P", {pp[1], ra[1], m_pp[1]}, 3'b101);
    step(9);
    chk("rep_P9", {pp[1], ra[1]}, 2'b00);
    step(1);
    chk("rep_P10", {pp[1], ra[1], m_ra[1]}, 3'b111);
    step(5);
    chk("rep_P15", {pp[1], ra[1]}, 2'b11);
    step(5);
    chk("rep_P20", {pp[1], ra[1]}, 2'b11);
    step(4);
    chk("rep_P24", {pp[1], ra[1]}, 2'b01);
    step(16);
    btn[1] = 1'b0;
    step(8);
    chk("rep_released", {lvl[1], ra[1]}, 2'b00);

    btn[1] = 1'b1;
    step(6);
    chk("col_P", pp[1], 1'b1);
    step(14);
    btn[1] = 1'b0;
    step(5);
    chk("col_P19", {rp[1], ra[1]}, 2'b01);
    step(1);
    chk("col_P20", {lvl[1], pp[1], rp[1], ra[1]}, 4'b0010);
    step(1);
    chk("col_P21", {pp[1], rp[1], ra[1]}, 3'b000);
    step(4);

    for (int n = 1; n <= 3; n++) begin
      btn[2] = 1'b0;
      step(6);
      chk("al_press", {lvl[2], pp[2]}, 2'b11);
      step(1);
      chk("tff_q", tq, n % 2);
      btn[2] = 1'b1;
      step(8);
    end
    chk("tff_final", tq, 1'b1);

    btn[1] = 1'b1;
    step(10);
    reset = 1'b1;
    step(1);
    chk("midrst_outs", {lvl[1], pp[1], rp[1], ra[1]}, 4'h0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("midrst_after", {lvl[1], pp[1]}, 2'b00);
    step(4);
    chk("midrst_edge5", {lvl[1], pp[1]}, 2'b00);
    step(1);
    chk("midrst_edge6", {lvl[1], pp[1]}, 2'b11);
    btn[1] = 1'b0;
    step(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
